// File: rtl/pipeline_hazard_unit.sv
// Data-hazard tracking for an in-order pipeline: post-decode destination tracking,
// operand forwarding, load-use stall generation, redirect flush and stall statistics.
module pipeline_hazard_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADDR      = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [RADDR-1:0]        id_rs1,
  input  logic [RADDR-1:0]        id_rs2,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [RADDR-1:0]        id_rd,
  input  logic                    id_wen,
  input  logic                    id_is_load,
  input  logic [XLEN-1:0]         id_rdata1,
  input  logic [XLEN-1:0]         id_rdata2,
  input  logic                    redirect,
  input  logic [DEPTH*XLEN-1:0]   stage_result,
  output logic                    issue,
  output logic                    stall,
  output logic                    flush_id,
  output logic [XLEN-1:0]         fwd_data1,
  output logic [XLEN-1:0]         fwd_data2,
  output logic [DEPTH-1:0]        stage_valid,
  output logic [15:0]             stall_count
);

  typedef struct packed {
    logic             valid;
    logic [RADDR-1:0] rd;
    logic             wen;
    logic             is_load;
  } entry_t;

  entry_t [DEPTH-1:0]        pipe_q;
  entry_t                    ins;
  logic [1:0][RADDR-1:0]     rs;
  logic [1:0]                used;
  logic [1:0][XLEN-1:0]      rdata;
  logic [1:0][XLEN-1:0]      fwd;
  logic [1:0]                hazard;

  assign rs    = {id_rs2, id_rs1};
  assign used  = {id_rs2_used, id_rs1_used};
  assign rdata = {id_rdata2, id_rdata1};

  // Scan oldest to youngest so the youngest matching stage has the final say.
  always_comb begin : operand_resolve
    fwd    = rdata;
    hazard = '0;
    for (int n = 0; n < 2; n++) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (used[n] && (rs[n] != '0) && pipe_q[k].valid && pipe_q[k].wen &&
            (pipe_q[k].rd == rs[n])) begin
          if (pipe_q[k].is_load && ((k + 1) < int'(LOAD_STAGE))) begin
            hazard[n] = 1'b1;
            fwd[n]    = rdata[n];
          end else begin
            hazard[n] = 1'b0;
            fwd[n]    = stage_result[k*int'(XLEN) +: XLEN];
          end
        end
      end
    end
  end

  assign fwd_data1 = fwd[0];
  assign fwd_data2 = fwd[1];
  assign flush_id  = redirect;
  assign stall     = id_valid & ~redirect & (|hazard);
  assign issue     = id_valid & ~stall & ~redirect;

  // Stage-1 input: a bubble unless the ID instruction actually issues; x0 is never a writer.
  always_comb begin : stage1_entry
    ins         = '0;
    ins.valid   = issue;
    ins.rd      = id_rd;
    ins.wen     = id_wen && (id_rd != '0);
    ins.is_load = id_is_load;
  end

  always_comb begin : occupancy
    stage_valid = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      stage_valid[k] = pipe_q[k].valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : track_regs
    if (!rst_n) begin
      pipe_q      <= '0;
      stall_count <= '0;
    end else begin
      pipe_q <= {pipe_q[DEPTH-2:0], ins};
      if (stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule
